// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_engine
// Purpose  : UART serial receive engine. Synchronises the async rx line,
//            detects the start bit, samples data/parity/stop at mid-bit and
//            delivers each frame as a one-cycle rx_valid pulse. Maintains the
//            sticky parity, data-bits and framing error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter int BAUD_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic [BAUD_WIDTH-1:0]    baud_rate,
    input  logic [3:0]               data_bits,
    input  logic                     odd_parity,
    input  logic                     parity_bit,
    input  logic                     err_clr,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    output logic                     parity_error,
    output logic                     data_bits_error,
    output logic                     frame_error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [BAUD_WIDTH-1:0] MIN_BAUD = BAUD_WIDTH'(2);
    localparam logic [BAUD_WIDTH-1:0] ONE      = BAUD_WIDTH'(1);

    // ------------------------------------------------------------------
    // Line synchroniser and edge detect
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;
    logic rx_s_d;
    logic rx_fall;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection;
    // all three reset to the idle (high) line level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign rx_fall = rx_s_d & ~rx_s;

    // ------------------------------------------------------------------
    // Per-frame configuration, captured at start detection
    // ------------------------------------------------------------------
    logic [BAUD_WIDTH-1:0] baud_q;
    logic [3:0]            nbits_q;
    logic                  par_en_q;
    logic                  par_odd_q;

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    state_t                   state;
    state_t                   state_d;
    logic [BAUD_WIDTH-1:0]    cnt;
    logic [BAUD_WIDTH-1:0]    cnt_d;
    logic [3:0]               bit_idx;
    logic [MAX_DATA_BITS-1:0] data_sr;
    logic                     parity_bad;

    // Strobes decoded by the next-state logic and consumed by the datapath
    logic                     cfg_ok;
    logic                     start_accept;
    logic                     cfg_err;
    logic                     sample_data;
    logic                     sample_parity;
    logic                     sample_stop;
    logic                     bit_tick;
    logic                     half_tick;
    logic                     last_data_bit;

    // A zero-length or over-long frame is rejected without leaving IDLE
    assign cfg_ok = (data_bits != 4'd0) && (int'(data_bits) <= MAX_DATA_BITS);

    assign bit_tick      = (cnt == baud_q - ONE);
    assign half_tick     = (cnt == (baud_q >> 1) - ONE);
    assign last_data_bit = (bit_idx == nbits_q - 4'd1);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic, bit-period counter and sampling strobes
    always_comb begin
        state_d       = state;
        cnt_d         = cnt + ONE;
        start_accept  = 1'b0;
        cfg_err       = 1'b0;
        sample_data   = 1'b0;
        sample_parity = 1'b0;
        sample_stop   = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    if (cfg_ok) begin
                        start_accept = 1'b1;
                        state_d      = ST_START;
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            ST_START: begin
                // Half a bit in: a still-low line confirms a real start bit
                if (half_tick) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_d       = '0;
                    sample_data = 1'b1;
                    if (last_data_bit) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_d         = '0;
                    sample_parity = 1'b1;
                    state_d       = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_d       = '0;
                    sample_stop = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Configuration capture; baud is clamped so the half-bit wait is never zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q    <= MIN_BAUD;
            nbits_q   <= 4'd1;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
        end else if (start_accept) begin
            baud_q    <= (baud_rate < MIN_BAUD) ? MIN_BAUD : baud_rate;
            nbits_q   <= data_bits;
            par_en_q  <= parity_bit;
            par_odd_q <= odd_parity;
        end
    end

    // Counter, bit index, shift register and pending parity result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= 4'd0;
            data_sr    <= '0;
            parity_bad <= 1'b0;
        end else begin
            cnt <= cnt_d;
            if (start_accept) begin
                bit_idx    <= 4'd0;
                data_sr    <= '0;
                parity_bad <= 1'b0;
            end
            if (sample_data) begin
                // LSB first; bits beyond the frame length stay zero
                for (int i = 0; i < MAX_DATA_BITS; i++) begin
                    if (bit_idx == 4'(i)) begin
                        data_sr[i] <= rx_s;
                    end
                end
                bit_idx <= bit_idx + 4'd1;
            end
            if (sample_parity) begin
                parity_bad <= ((^data_sr) ^ rx_s) != par_odd_q;
            end
        end
    end

    // Frame delivery and registered busy indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= sample_stop;
            busy     <= (state_d != ST_IDLE);
            if (sample_stop) begin
                rx_data <= data_sr;
            end
        end
    end

    // Sticky error flags; a new error event takes priority over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_error    <= 1'b0;
            data_bits_error <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            if (sample_stop && par_en_q && parity_bad) begin
                parity_error <= 1'b1;
            end else if (err_clr) begin
                parity_error <= 1'b0;
            end

            if (cfg_err) begin
                data_bits_error <= 1'b1;
            end else if (err_clr) begin
                data_bits_error <= 1'b0;
            end

            if (sample_stop && !rx_s) begin
                frame_error <= 1'b1;
            end else if (err_clr) begin
                frame_error <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
